// File: rtl/can_pkg.sv
// Shared CAN MAC definitions: stuffing run length and RX destuffer state encoding.
package can_pkg;

  localparam int unsigned CAN_STUFF_LEN = 5;
  localparam int unsigned CAN_RUN_CNT_W = 3;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStuff,
    StError
  } can_rx_destuff_state_t;

endpackage

// File: rtl/can_mac_rx_deserializer_if.sv
// Bit-stream bus between the bit sampler (master) and the RX destuffer (slave).
interface can_mac_rx_deserializer_if;

  logic bit_in;
  logic bit_valid;
  logic destuffing_enable;
  logic bit_out;
  logic valid;
  logic stuff_error;

  modport master (
    output bit_in,
    output bit_valid,
    output destuffing_enable,
    input  bit_out,
    input  valid,
    input  stuff_error
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    input  destuffing_enable,
    output bit_out,
    output valid,
    output stuff_error
  );

endinterface

// File: rtl/can_stuff_run_tracker.sv
// Tracks the current run of identical bus bits; shared by the RX destuffer and TX serializer.
module can_stuff_run_tracker
  import can_pkg::*;
#(
  parameter int unsigned StuffLen = CAN_STUFF_LEN
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     bit_i,
  input  logic                     strobe_i,
  input  logic                     restart_i,
  input  logic                     clear_i,
  output logic                     last_bit_o,
  output logic [CAN_RUN_CNT_W-1:0] run_cnt_o,
  output logic                     run_full_o
);

  logic                     last_bit_q, last_bit_d;
  logic [CAN_RUN_CNT_W-1:0] run_cnt_q, run_cnt_d;

  // restart_i forces a fresh run of length one starting with bit_i.
  always_comb begin
    last_bit_d = last_bit_q;
    run_cnt_d  = run_cnt_q;
    if (clear_i) begin
      last_bit_d = 1'b0;
      run_cnt_d  = '0;
    end else if (strobe_i) begin
      if (!restart_i && (run_cnt_q != '0) && (bit_i == last_bit_q)) begin
        run_cnt_d = run_cnt_q + CAN_RUN_CNT_W'(1);
      end else begin
        last_bit_d = bit_i;
        run_cnt_d  = CAN_RUN_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_bit_q <= 1'b0;
      run_cnt_q  <= '0;
    end else begin
      last_bit_q <= last_bit_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  assign last_bit_o = last_bit_q;
  assign run_cnt_o  = run_cnt_q;
  assign run_full_o = strobe_i && !clear_i && (run_cnt_d == CAN_RUN_CNT_W'(StuffLen));

endmodule

// File: rtl/can_mac_rx_deserializer.sv
// CAN RX bit destuffer: drops stuff bits, forwards data bits with one cycle of latency.
// Define CAN_RX_STUFF_ERR_EN to flag stuff violations and lock out until disable/reset.
module can_mac_rx_deserializer
  import can_pkg::*;
#(
  parameter int unsigned STUFF_LEN = CAN_STUFF_LEN
) (
  input logic                        clk,
  input logic                        reset,
  can_mac_rx_deserializer_if.slave   bus
);

  can_rx_destuff_state_t    st_q;
  logic                     bit_out_q;
  logic                     valid_q;
  logic                     last_bit;
  logic                     run_full;
  logic [CAN_RUN_CNT_W-1:0] run_cnt;
  logic                     violation;
  logic                     trk_strobe;
  logic                     trk_restart;

  assign violation   = (st_q == StStuff) && (bus.bit_in == last_bit);
  assign trk_strobe  = bus.bit_valid && bus.destuffing_enable && (st_q != StError);
  assign trk_restart = (st_q == StIdle) || violation;

  can_stuff_run_tracker #(
    .StuffLen (STUFF_LEN)
  ) u_run_tracker (
    .clk_i      (clk),
    .reset_i    (reset),
    .bit_i      (bus.bit_in),
    .strobe_i   (trk_strobe),
    .restart_i  (trk_restart),
    .clear_i    (!bus.destuffing_enable),
    .last_bit_o (last_bit),
    .run_cnt_o  (run_cnt),
    .run_full_o (run_full)
  );

`ifdef CAN_RX_STUFF_ERR_EN
  logic stuff_error_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= StIdle;
      bit_out_q <= 1'b0;
      valid_q   <= 1'b0;
`ifdef CAN_RX_STUFF_ERR_EN
      stuff_error_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (!bus.destuffing_enable) begin
        st_q <= StIdle;
`ifdef CAN_RX_STUFF_ERR_EN
        stuff_error_q <= 1'b0;
`endif
        if (bus.bit_valid) begin
          valid_q   <= 1'b1;
          bit_out_q <= bus.bit_in;
        end
      end else if (bus.bit_valid) begin
        unique case (st_q)
          StIdle: begin
            valid_q   <= 1'b1;
            bit_out_q <= bus.bit_in;
            st_q      <= run_full ? StStuff : StRun;
          end
          StRun: begin
            valid_q   <= 1'b1;
            bit_out_q <= bus.bit_in;
            if (run_full) st_q <= StStuff;
          end
          StStuff: begin
            if (violation) begin
`ifdef CAN_RX_STUFF_ERR_EN
              st_q          <= StError;
              stuff_error_q <= 1'b1;
`else
              st_q <= StRun;
`endif
            end else begin
              st_q <= StRun;
            end
          end
          StError: begin
`ifndef CAN_RX_STUFF_ERR_EN
            st_q <= StIdle;
`endif
          end
          default: st_q <= StIdle;
        endcase
      end
    end
  end

  // The tracker restarts on every stuff slot, so a run can never exceed STUFF_LEN.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (run_cnt <= CAN_RUN_CNT_W'(STUFF_LEN));
    end
  end

  assign bus.bit_out = bit_out_q;
  assign bus.valid   = valid_q;
`ifdef CAN_RX_STUFF_ERR_EN
  assign bus.stuff_error = stuff_error_q;
`else
  assign bus.stuff_error = 1'b0;
`endif

endmodule

// File: tb/tb_can_mac_rx_deserializer.sv
// Self-checking bench for can_mac_rx_deserializer: directed streams plus randomized model checks.
module tb_can_mac_rx_deserializer;
  import can_pkg::*;

  localparam int unsigned SL = CAN_STUFF_LEN;
`ifdef CAN_RX_STUFF_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  can_mac_rx_deserializer_if bus ();

  can_mac_rx_deserializer #(
    .STUFF_LEN (SL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference: count identical bits; after SL of them the next bit must be the complement.
  int m_run;
  bit m_last;
  bit m_due;
  bit m_err;
  bit got_q[$];

  function automatic void model_clear();
    m_run  = 0;
    m_last = 1'b0;
    m_due  = 1'b0;
    m_err  = 1'b0;
  endfunction

  function automatic void model_step(input bit b, input bit en, output bit fwd);
    fwd = 1'b0;
    if (!en) begin
      fwd = 1'b1;
      model_clear();
    end else if (m_err) begin
      fwd = 1'b0;
    end else if (m_due) begin
      m_due = 1'b0;
      m_run = 1;
      if (b == m_last) begin
        if (ErrEn) m_err = 1'b1;
      end else begin
        m_last = b;
      end
    end else begin
      fwd = 1'b1;
      if (m_run > 0 && b == m_last) m_run++;
      else begin
        m_last = b;
        m_run  = 1;
      end
      if (m_run == SL) m_due = 1'b1;
    end
  endfunction

  task automatic drive(input bit b);
    bit fwd;
    @(negedge clk);
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    model_step(b, bus.destuffing_enable, fwd);
    @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
    checks++;
    if (bus.valid !== fwd) begin
      errors++;
      $display("FAIL strobe_valid: got %b want %b (bit %b)", bus.valid, fwd, b);
    end
    if (fwd) begin
      checks++;
      if (bus.bit_out !== b) begin
        errors++;
        $display("FAIL strobe_bit_out: got %b want %b", bus.bit_out, b);
      end
    end
    if (bus.valid === 1'b1) got_q.push_back(bus.bit_out);
    checks++;
    if (bus.stuff_error !== m_err) begin
      errors++;
      $display("FAIL strobe_stuff_error: got %b want %b", bus.stuff_error, m_err);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.bit_valid = 1'b0;
      if (!bus.destuffing_enable) model_clear();
      @(posedge clk);
      #1;
      checks++;
      if (bus.valid !== 1'b0 || bus.stuff_error !== m_err) begin
        errors++;
        $display("FAIL idle_cycle: valid %b err %b want valid 0 err %b",
                 bus.valid, bus.stuff_error, m_err);
      end
    end
  endtask

  task automatic send(input bit s[$], input int max_gap);
    foreach (s[i]) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      drive(s[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.bit_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    got_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.bit_in = 1'b1;
    bus.bit_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.valid !== 1'b0 || bus.bit_out !== 1'b0 || bus.stuff_error !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: valid %b bit_out %b err %b want 0 0 0",
               bus.valid, bus.bit_out, bus.stuff_error);
    end
    do_reset();
  endtask

  task automatic test_stuffed_ones(input int gap);
    bit s[$]   = '{0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 1, 0};
    bit exp[$] = '{0, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0};
    do_reset();
    bus.destuffing_enable = 1'b1;
    send(s, gap);
    checks++;
    if (got_q.size() != exp.size() || got_q != exp) begin
      errors++;
      $display("FAIL stuffed_ones gap%0d: got %p want %p", gap, got_q, exp);
    end
  endtask

  task automatic test_new_run();
    bit s[$]   = '{0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
    bit exp[$] = '{0, 1, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0};
    do_reset();
    bus.destuffing_enable = 1'b1;
    send(s, 0);
    checks++;
    if (got_q != exp) begin
      errors++;
      $display("FAIL stuff_new_run: got %p want %p", got_q, exp);
    end
  endtask

  task automatic test_violation();
    bit s[$] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    bit exp[$];
    do_reset();
    bus.destuffing_enable = 1'b1;
    send(s, 0);
    if (ErrEn) exp = '{0, 1, 1, 1, 1, 1};
    else exp = '{0, 1, 1, 1, 1, 1, 1, 0};
    checks++;
    if (got_q != exp) begin
      errors++;
      $display("FAIL violation_stream: got %p want %p", got_q, exp);
    end
    checks++;
    if (bus.stuff_error !== ErrEn) begin
      errors++;
      $display("FAIL violation_flag: got %b want %b", bus.stuff_error, ErrEn);
    end
    bus.destuffing_enable = 1'b0;
    idle(1);
    checks++;
    if (bus.stuff_error !== 1'b0) begin
      errors++;
      $display("FAIL violation_clear: got %b want 0", bus.stuff_error);
    end
  endtask

  task automatic test_pass_through();
    bit s[$] = '{1, 1, 1, 1, 1, 1, 1};
    do_reset();
    bus.destuffing_enable = 1'b0;
    send(s, 1);
    checks++;
    if (got_q != s) begin
      errors++;
      $display("FAIL pass_through: got %p want %p", got_q, s);
    end
  endtask

  task automatic test_reset_mid_run();
    bit s[$] = '{1, 1, 1, 1};
    bit t[$] = '{1, 1};
    do_reset();
    bus.destuffing_enable = 1'b1;
    send(s, 0);
    @(negedge clk);
    reset = 1'b1;
    bus.bit_in = 1'b1;
    bus.bit_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run_valid: got %b want 0", bus.valid);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.bit_valid = 1'b0;
    model_clear();
    got_q.delete();
    send(t, 2);
    checks++;
    if (got_q != t) begin
      errors++;
      $display("FAIL reset_mid_run_out: got %p want %p", got_q, t);
    end
  endtask

  task automatic test_random_stuffed();
    for (int f = 0; f < 6; f++) begin
      bit data[$];
      bit wire_q[$];
      bit d = 1'b0;
      bit last = 1'b0;
      int run = 0;
      for (int i = 0; i < 48; i++) begin
        if ($urandom_range(0, 4) == 0) d = ~d;
        data.push_back(d);
      end
      foreach (data[i]) begin
        wire_q.push_back(data[i]);
        if (run > 0 && data[i] == last) run++;
        else begin
          last = data[i];
          run  = 1;
        end
        if (run == SL) begin
          wire_q.push_back(~data[i]);
          last = ~data[i];
          run  = 1;
        end
      end
      do_reset();
      bus.destuffing_enable = 1'b1;
      send(wire_q, f % 3);
      checks++;
      if (got_q != data || bus.stuff_error !== 1'b0) begin
        errors++;
        $display("FAIL random_frame%0d: got %0d bits err %b want %0d bits err 0",
                 f, got_q.size(), bus.stuff_error, data.size());
      end
    end
  endtask

  task automatic test_random_model();
    bit b = 1'b0;
    do_reset();
    bus.destuffing_enable = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) b = ~b;
      if ($urandom_range(0, 39) == 0) bus.destuffing_enable = ~bus.destuffing_enable;
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
      drive(b);
    end
  endtask

  initial begin
    reset                 = 1'b1;
    bus.bit_in            = 1'b0;
    bus.bit_valid         = 1'b0;
    bus.destuffing_enable = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    test_reset();
    test_stuffed_ones(0);
    test_stuffed_ones(3);
    test_new_run();
    test_violation();
    test_pass_through();
    test_reset_mid_run();
    test_random_stuffed();
    test_random_model();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/can_mac_rx_deserializer.md
# can_mac_rx_deserializer

Receive-side bit destuffer for the CAN MAC. It sits between the bit-timing/sampling logic and the RX frame parser. It consumes one sampled bus bit per strobe and removes the complement bit the transmitter inserts after five identical bits. It forwards the remaining data bits in order and flags a stuff error when a sixth identical bit arrives where a stuff bit was required.

## Interface
Parameters:
- STUFF_LEN, 5, number of identical consecutive bits after which one stuff bit is expected.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- bit_in  in  1  sampled bus bit, MSB-first stream order.
- bit_valid  in  1  strobe: bit_in is a new bus bit this cycle.
- destuffing_enable  in  1  1 = destuff and check (SOF through CRC); 0 = pass-through.
- bit_out  out  1  destuffed data bit.
- valid  out  1  one-cycle strobe: bit_out holds a data bit.
- stuff_error  out  1  sticky stuff-rule violation flag.

There is no backpressure; the downstream block must accept every `valid` strobe.

## Operation
- Internal state: `last_bit`, `run_cnt` (3 bits, range 1..STUFF_LEN), and FSM `st` with states IDLE, RUN, STUFF and ERROR.
- Nothing changes in cycles with `bit_valid`=0. `valid` is 0 in those cycles.
- **IDLE**, on a strobe: forward the bit, set `last_bit`=bit and `run_cnt`=1, go to RUN.
- **RUN**, on a strobe: forward the bit.
  - If bit==`last_bit`: `run_cnt`++.
  - Otherwise: `last_bit`=bit and `run_cnt`=1.
  - If the new `run_cnt`==STUFF_LEN, go to STUFF.
- **STUFF**, on a strobe:
  - If bit != `last_bit`: the bit is a stuff bit and is dropped (`valid`=0). Set `last_bit`=bit and `run_cnt`=1, because the stuff bit starts a new run. Return to RUN.
  - If bit == `last_bit`: this is a violation. Behaviour depends on the Configuration section.
- **ERROR**: drop all bits and keep `stuff_error`=1. Leave ERROR only when reset is asserted or `destuffing_enable`=0, and go to IDLE.
- `destuffing_enable`=0: every strobed bit is forwarded, `st` is forced to IDLE, and `stuff_error` is cleared. A strobe in the same cycle that enable falls is treated as pass-through.
- A strobe in the same cycle as `reset`=1 is ignored; reset wins.

## Timing
- Reset values: `bit_out`=0, `valid`=0, `stuff_error`=0, `st`=IDLE, `run_cnt`=0, `last_bit`=0.
- Latency is one cycle. A strobe at posedge N produces registered `valid`/`bit_out` after posedge N, visible during cycle N+1.
- `valid` is high for exactly one cycle per forwarded bit. Back-to-back strobes give back-to-back `valid`.
- `stuff_error` goes high in the same cycle that `valid` would have appeared for the offending bit, and stays high.
- When reset is asserted mid-run, all state clears on the next posedge and no partial output follows.

## Configuration
- `CAN_RX_STUFF_ERR_EN` defined:
  - A violation in STUFF sets `stuff_error`, drops the bit, and enters ERROR.
- Not defined:
  - A violation is dropped as though it were a stuff bit. `run_cnt`=1 and `st` returns to RUN.
  - `stuff_error` is tied to 0 and the ERROR state is unused.

## Structure
- `can_pkg` holds:
  - the `can_rx_destuff_state_t` enum (IDLE, RUN, STUFF, ERROR);
  - `CAN_STUFF_LEN`=5, which is shared with the TX serializer.
- One sub-module is natural: `can_stuff_run_tracker`. It takes bit, strobe and clear, and produces `last_bit`, `run_cnt` and `run_full`. The TX serializer reuses it.

## Test plan
- **Stuffed 1s.** Enable=1. Stream 0,1,0,1,1,1,1,1,0,0,1,0 (12 strobes) → 11 `valid` strobes carrying 0,1,0,1,1,1,1,1,0,1,0. `stuff_error`=0.
- **Stuff bit starts a new run.** Stream 0,1,0,1,1,1,1,1,0,0,0,0,0,1,1,0 (16 strobes) → 14 bits 0,1,0,1,1,1,1,1,0,0,0,0,1,0. Both stuff bits are dropped.
- **Violation, macro defined.** Stream 0,1,1,1,1,1,1 → 6 `valid` strobes (0,1,1,1,1,1), then `stuff_error`=1 on the 7th strobe. Later strobes produce no `valid`. Enable=0 clears the flag.
- **Violation, macro undefined.** Same stream → 6 `valid` strobes and `stuff_error` stays 0. The following bit 1 is forwarded.
- **Pass-through.** Enable=0. Stream 1,1,1,1,1,1,1 → 7 `valid` strobes of 1.
- **Gaps and reset.** Strobes with idle gaps produce identical output. Asserting reset after four 1s, then sending 1,1 → no stuff expected, both bits forwarded.
